// File: rtl/uart_frame_responder.sv
// Receive-side UART command parser: turns AA/BB byte frames into register-file
// writes and reads and queues the response byte (ACK or read data) into the TX FIFO.
module uart_frame_responder #(
   parameter int                   WIDTH_REG   = 8,
   parameter int                   ADDR_W      = 4,
   parameter logic [WIDTH_REG-1:0] CMD_WR      = 8'hAA,
   parameter logic [WIDTH_REG-1:0] CMD_RD      = 8'hBB,
   parameter logic [WIDTH_REG-1:0] ACK_BYTE    = 8'h5A,
   parameter int                   TIMEOUT_CYC = 1024
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH_REG-1:0] i_rx_data,
   input  logic                 i_rx_valid,
   input  logic                 i_par_err,
   input  logic                 i_stp_err,
   output logic [ADDR_W-1:0]    o_rf_addr,
   output logic                 o_rf_wr_en,
   output logic [WIDTH_REG-1:0] o_rf_wr_data,
   output logic                 o_rf_rd_en,
   input  logic [WIDTH_REG-1:0] i_rf_rd_data,
   input  logic                 i_rf_rd_valid,
   output logic [WIDTH_REG-1:0] o_fifo_wr_data,
   output logic                 o_fifo_wr_en,
   input  logic                 i_fifo_full,
   output logic                 o_frame_err,
   output logic                 o_timeout
);

   localparam int                 CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_ADDR,
      S_WR_DATA,
      S_RD_ADDR,
      S_RD_WAIT,
      S_RESP
   } state_t;

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   logic [WIDTH_REG-1:0] resp;
   logic                 rx_err;
   logic                 rx_ok;
   logic                 expired;

   assign rx_err  = i_rx_valid & (i_par_err | i_stp_err);
   assign rx_ok   = i_rx_valid & ~(i_par_err | i_stp_err);
   assign expired = (cnt == CNT_MAX);

   // NOTE: every register here is state, so all assignments are non-blocking;
   // blocking ones would make later reads in this block see the new value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= S_IDLE;
         cnt            <= '0;
         resp           <= '0;
         o_rf_addr      <= '0;
         o_rf_wr_en     <= 1'b0;
         o_rf_wr_data   <= '0;
         o_rf_rd_en     <= 1'b0;
         o_fifo_wr_data <= '0;
         o_fifo_wr_en   <= 1'b0;
         o_frame_err    <= 1'b0;
         o_timeout      <= 1'b0;
      end else begin
         // Strobes default low so each one lasts exactly one clock.
         o_rf_wr_en   <= 1'b0;
         o_rf_rd_en   <= 1'b0;
         o_fifo_wr_en <= 1'b0;
         o_frame_err  <= 1'b0;
         o_timeout    <= 1'b0;

         case (state)
            S_IDLE: begin
               if (rx_err) begin
                  o_frame_err <= 1'b1;
               end else if (rx_ok && i_rx_data == CMD_WR) begin
                  state <= S_WR_ADDR;
                  cnt   <= '0;
               end else if (rx_ok && i_rx_data == CMD_RD) begin
                  state <= S_RD_ADDR;
                  cnt   <= '0;
               end
            end

            S_WR_ADDR: begin
               if (rx_err) begin
                  o_frame_err <= 1'b1;
                  state       <= S_IDLE;
               end else if (rx_ok) begin
                  o_rf_addr <= i_rx_data[ADDR_W-1:0];
                  cnt       <= '0;
                  state     <= S_WR_DATA;
               end else if (expired) begin
                  o_timeout <= 1'b1;
                  state     <= S_IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            S_WR_DATA: begin
               if (rx_err) begin
                  o_frame_err <= 1'b1;
                  state       <= S_IDLE;
               end else if (rx_ok) begin
                  o_rf_wr_data <= i_rx_data;
                  o_rf_wr_en   <= 1'b1;
                  resp         <= ACK_BYTE;
                  state        <= S_RESP;
               end else if (expired) begin
                  o_timeout <= 1'b1;
                  state     <= S_IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            S_RD_ADDR: begin
               if (rx_err) begin
                  o_frame_err <= 1'b1;
                  state       <= S_IDLE;
               end else if (rx_ok) begin
                  o_rf_addr  <= i_rx_data[ADDR_W-1:0];
                  o_rf_rd_en <= 1'b1;
                  state      <= S_RD_WAIT;
               end else if (expired) begin
                  o_timeout <= 1'b1;
                  state     <= S_IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            // Push straight from here when the FIFO has room to keep the
            // read-valid to push latency at one clock.
            S_RD_WAIT: begin
               if (i_rf_rd_valid) begin
                  resp <= i_rf_rd_data;
                  if (!i_fifo_full) begin
                     o_fifo_wr_data <= i_rf_rd_data;
                     o_fifo_wr_en   <= 1'b1;
                     state          <= S_IDLE;
                  end else begin
                     state <= S_RESP;
                  end
               end
            end

            S_RESP: begin
               if (!i_fifo_full) begin
                  o_fifo_wr_data <= resp;
                  o_fifo_wr_en   <= 1'b1;
                  state          <= S_IDLE;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_frame_responder.sv
// Self-checking bench for uart_frame_responder: directed test-plan frames plus
// randomized write/read/junk/error frames checked against a shadow register model.
module tb_uart_frame_responder;

   localparam int          W   = 8;
   localparam int          AW  = 4;
   localparam int          TO  = 1024;
   localparam logic [7:0]  WR  = 8'hAA;
   localparam logic [7:0]  RD  = 8'hBB;
   localparam logic [7:0]  ACK = 8'h5A;

   logic          clk = 1'b0;
   logic          reset;
   logic [W-1:0]  rx_data;
   logic          rx_valid, par_err, stp_err;
   logic [AW-1:0] rf_addr;
   logic          rf_wr_en, rf_rd_en;
   logic [W-1:0]  rf_wr_data, rf_rd_data;
   logic          rf_rd_valid;
   logic [W-1:0]  fifo_wr_data;
   logic          fifo_wr_en, fifo_full;
   logic          frame_err, timeout;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] shadow [1<<AW];

   uart_frame_responder #(
      .WIDTH_REG(W), .ADDR_W(AW), .CMD_WR(WR), .CMD_RD(RD),
      .ACK_BYTE(ACK), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .reset(reset),
      .i_rx_data(rx_data), .i_rx_valid(rx_valid),
      .i_par_err(par_err), .i_stp_err(stp_err),
      .o_rf_addr(rf_addr), .o_rf_wr_en(rf_wr_en), .o_rf_wr_data(rf_wr_data),
      .o_rf_rd_en(rf_rd_en), .i_rf_rd_data(rf_rd_data), .i_rf_rd_valid(rf_rd_valid),
      .o_fifo_wr_data(fifo_wr_data), .o_fifo_wr_en(fifo_wr_en), .i_fifo_full(fifo_full),
      .o_frame_err(frame_err), .o_timeout(timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet(input string tag);
      check({tag, "_wr_en"}, rf_wr_en, 0);
      check({tag, "_rd_en"}, rf_rd_en, 0);
      check({tag, "_push"},  fifo_wr_en, 0);
      check({tag, "_ferr"},  frame_err, 0);
      check({tag, "_tmo"},   timeout, 0);
   endtask

   task automatic send(input logic [7:0] b, input logic pe = 1'b0, input logic se = 1'b0);
      rx_data  = b;
      rx_valid = 1'b1;
      par_err  = pe;
      stp_err  = se;
      tick();
      rx_valid = 1'b0;
      par_err  = 1'b0;
      stp_err  = 1'b0;
      rx_data  = W'($urandom);
   endtask

   // Full write frame; FIFO held full for nfull sampled edges before the push.
   task automatic do_write(input logic [7:0] ab, input logic [7:0] d, input int nfull);
      logic [AW-1:0] a;
      a = AW'(ab % (1 << AW));
      send(WR);  quiet("wr_cmd");
      send(ab);  quiet("wr_adr");
      send(d);
      check("wr_en", rf_wr_en, 1);
      check("wr_addr", rf_addr, a);
      check("wr_data", rf_wr_data, d);
      check("wr_nopush", fifo_wr_en, 0);
      shadow[a] = d;
      fifo_full = (nfull > 0);
      tick();
      check("wr_en_1cyc", rf_wr_en, 0);
      if (nfull > 0) begin
         check("wr_bp_nopush", fifo_wr_en, 0);
         for (int i = 1; i < nfull; i++) begin
            tick();
            check("wr_bp_nopush", fifo_wr_en, 0);
         end
         fifo_full = 1'b0;
         tick();
      end
      check("wr_push", fifo_wr_en, 1);
      check("wr_ack", fifo_wr_data, ACK);
      tick();
      quiet("wr_after");
   endtask

   // Full read frame; the bench plays the register file returning shadow[addr].
   task automatic do_read(input logic [7:0] ab, input int lat, input int nfull, input bit junk);
      logic [AW-1:0] a;
      logic [W-1:0]  d;
      a = AW'(ab % (1 << AW));
      d = shadow[a];
      send(RD);  quiet("rd_cmd");
      send(ab);
      check("rd_en", rf_rd_en, 1);
      check("rd_addr", rf_addr, a);
      check("rd_nopush", fifo_wr_en, 0);
      for (int i = 0; i < lat; i++) begin
         if (junk && i == 0) send(WR, 1'(($urandom & 1)), 1'b0);
         else tick();
         quiet("rd_wait");
      end
      rf_rd_valid = 1'b1;
      rf_rd_data  = d;
      fifo_full   = (nfull > 0);
      tick();
      rf_rd_valid = 1'b0;
      rf_rd_data  = W'($urandom);
      if (nfull > 0) begin
         check("rd_bp_nopush", fifo_wr_en, 0);
         for (int i = 1; i < nfull; i++) begin
            tick();
            check("rd_bp_nopush", fifo_wr_en, 0);
         end
         fifo_full = 1'b0;
         tick();
      end
      check("rd_push", fifo_wr_en, 1);
      check("rd_push_data", fifo_wr_data, d);
      tick();
      quiet("rd_after");
   endtask

   initial begin
      int n;
      logic [7:0] cmd, eb;
      int pos;

      reset       = 1'b1;
      rx_data     = '0;
      rx_valid    = 1'b0;
      par_err     = 1'b0;
      stp_err     = 1'b0;
      rf_rd_data  = '0;
      rf_rd_valid = 1'b0;
      fifo_full   = 1'b0;
      for (int i = 0; i < (1 << AW); i++) shadow[i] = W'($urandom);

      tick();
      tick();
      quiet("rst");
      check("rst_addr", rf_addr, 0);
      check("rst_wdata", rf_wr_data, 0);
      check("rst_fdata", fifo_wr_data, 0);
      reset = 1'b0;
      tick();

      // Basic write and read.
      do_write(8'h03, 8'hC4, 0);
      shadow[7] = 8'h3E;
      do_read(8'h07, 2, 0, 1'b0);

      // Backpressure on the read response.
      do_read(8'h07, 1, 20, 1'b0);

      // Parity error on the data byte aborts the write.
      send(WR);
      send(8'h05);
      send(8'hC4, 1'b1, 1'b0);
      check("perr_pulse", frame_err, 1);
      check("perr_nowr", rf_wr_en, 0);
      check("perr_nopush", fifo_wr_en, 0);
      tick();
      quiet("perr_after");
      do_write(8'h05, 8'h11, 0);

      // Inter-byte timeout after the command byte.
      send(WR);
      n = 0;
      while (n < TO + 10 && !timeout) begin
         tick();
         n++;
         check("tmo_noerr", frame_err, 0);
      end
      check("tmo_latency", n, TO);
      check("tmo_pulse", timeout, 1);
      tick();
      check("tmo_1cyc", timeout, 0);
      send(8'h11);
      quiet("tmo_junk");
      tick();
      quiet("tmo_junk2");
      do_write(8'h01, 8'h22, 0);

      // A byte arriving on the expiry cycle wins over the timeout.
      send(WR);
      repeat (TO - 1) tick();
      check("tmo_edge_early", timeout, 0);
      send(8'hF6);
      check("tmo_edge_byte", timeout, 0);
      send(8'h77);
      check("tmo_edge_wr", rf_wr_en, 1);
      check("tmo_edge_addr", rf_addr, 6);
      check("tmo_edge_data", rf_wr_data, 8'h77);
      shadow[6] = 8'h77;
      tick();
      check("tmo_edge_push", fifo_wr_en, 1);
      check("tmo_edge_ack", fifo_wr_data, ACK);
      tick();

      // Junk byte in IDLE is ignored.
      send(8'h00);
      quiet("junk");
      tick();
      quiet("junk2");

      // Reset in the middle of a write frame.
      send(WR);
      send(8'h02);
      reset = 1'b1;
      #1;
      quiet("mid_rst");
      check("mid_rst_addr", rf_addr, 0);
      check("mid_rst_wdata", rf_wr_data, 0);
      check("mid_rst_fdata", fifo_wr_data, 0);
      tick();
      reset = 1'b0;
      send(8'h99);
      quiet("post_rst");
      tick();
      quiet("post_rst2");

      // Randomized frames against the shadow model.
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 3))
            0: do_write(8'($urandom), 8'($urandom), $urandom_range(0, 3));
            1: do_read(8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom & 1));
            2: begin
               do eb = 8'($urandom); while (eb == WR || eb == RD);
               send(eb);
               quiet("rnd_junk");
               tick();
               quiet("rnd_junk2");
            end
            default: begin
               cmd = ($urandom & 1) ? WR : RD;
               pos = (cmd == WR) ? $urandom_range(0, 2) : $urandom_range(0, 1);
               if (pos >= 1) send(cmd);
               if (pos == 2) send(8'($urandom));
               if ($urandom & 1) send(8'($urandom), 1'b1, 1'($urandom & 1));
               else              send(8'($urandom), 1'b0, 1'b1);
               check("rnd_err_pulse", frame_err, 1);
               check("rnd_err_nowr", rf_wr_en, 0);
               check("rnd_err_nord", rf_rd_en, 0);
               check("rnd_err_nopush", fifo_wr_en, 0);
               tick();
               quiet("rnd_err_after");
            end
         endcase
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
